cache_refill_ctrl: RTL and testbench

- Miss-handling stage directly downstream of the cache's LRU victim selector.
- Consumes the one-hot victim way select and the miss address.
- If the victim line is valid and dirty, writes it back to memory. Then fetches the new line word by word, writes it into the victim way, and commits tag/valid.
- Stalls the pipeline for the whole operation.

---
 rtl/cache_refill_ctrl_pkg.sv | 25 ++
 rtl/cache_refill_ctrl_way_prio_onehot.sv | 14 +
 rtl/cache_refill_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared sizing, refill FSM encoding and victim-way codes for the miss refill path.
package cache_refill_ctrl_pkg;

  localparam int unsigned CACHE_WAY_NUM     = 4;
  localparam int unsigned CACHE_INDEX_WIDTH = 7;
  localparam int unsigned CACHE_TAG_WIDTH   = 21;
  localparam int unsigned CACHE_LINE_WORDS  = 4;
  localparam int unsigned CACHE_DATA_WIDTH  = 32;
  localparam int unsigned CACHE_ADDR_WIDTH  = 32;

  typedef enum logic [2:0] {
    REFILL_IDLE   = 3'd0,
    REFILL_WB     = 3'd1,
    REFILL_RD     = 3'd2,
    REFILL_COMMIT = 3'd3,
    REFILL_DONE   = 3'd4
  } refill_state_e;

  localparam logic [CACHE_WAY_NUM-1:0] REPLACE_WAY0   = CACHE_WAY_NUM'(1);
  localparam logic [CACHE_WAY_NUM-1:0] REPLACE_WAY1   = CACHE_WAY_NUM'(2);
  localparam logic [CACHE_WAY_NUM-1:0] REPLACE_WAY2   = CACHE_WAY_NUM'(4);
  localparam logic [CACHE_WAY_NUM-1:0] REPLACE_WAY3   = CACHE_WAY_NUM'(8);
  localparam logic [CACHE_WAY_NUM-1:0] NO_REPLACE_WAY = CACHE_WAY_NUM'(0);

endpackage

// File: rtl/cache_refill_ctrl_way_prio_onehot.sv
// Reduces a (normally one-hot) victim vector to its lowest set bit.
module way_prio_onehot
  import cache_refill_ctrl_pkg::*;
#(
  parameter int unsigned WAY_NUM = CACHE_WAY_NUM
) (
  input  logic [WAY_NUM-1:0] i_vec,
  output logic [WAY_NUM-1:0] o_onehot_c
);

  // x & -x isolates the least significant set bit; zero in gives zero out
  assign o_onehot_c = i_vec & (~i_vec + WAY_NUM'(1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss refill controller: optional dirty-victim write-back, line fetch, tag commit.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int unsigned WAY_NUM     = CACHE_WAY_NUM,
  parameter int unsigned INDEX_WIDTH = CACHE_INDEX_WIDTH,
  parameter int unsigned TAG_WIDTH   = CACHE_TAG_WIDTH,
  parameter int unsigned LINE_WORDS  = CACHE_LINE_WORDS,
  parameter int unsigned DATA_WIDTH  = CACHE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = CACHE_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          miss_req,
  input  logic [TAG_WIDTH-1:0]          miss_tag,
  input  logic [INDEX_WIDTH-1:0]        miss_index,
  input  logic [WAY_NUM-1:0]            replace_en,
  input  logic                          victim_valid,
  input  logic                          victim_dirty,
  input  logic [TAG_WIDTH-1:0]          victim_tag,
  input  logic [DATA_WIDTH-1:0]         victim_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_ack,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic [WAY_NUM-1:0]            way_sel,
  output logic [INDEX_WIDTH-1:0]        arr_index,
  output logic [$clog2(LINE_WORDS)-1:0] arr_word,
  output logic                          data_we,
  output logic [DATA_WIDTH-1:0]         data_wdata,
  output logic                          tag_we,
  output logic [TAG_WIDTH-1:0]          tag_wdata,
  output logic                          valid_clr,
  output logic                          stall,
  output logic                          refill_done
);

  localparam int unsigned CW = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);

  refill_state_e          r_state;
  logic [CW-1:0]          r_cnt;
  logic [WAY_NUM-1:0]     r_way;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [TAG_WIDTH-1:0]   r_vtag;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic                   r_tag_we;
  logic                   r_done;
  logic                   r_stall;

  logic [WAY_NUM-1:0]     w_onehot;
  logic                   w_accept;
  logic                   w_wb;
  logic                   w_last;
  logic                   w_data_we;
  logic [CW-1:0]          w_cnt_inc;

  // Word-aligned beat address from tag, set index and word offset
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(
    input logic [TAG_WIDTH-1:0]   tag,
    input logic [INDEX_WIDTH-1:0] idx,
    input logic [CW-1:0]          word
  );
    return ADDR_WIDTH'({tag, idx, word, 2'b00});
  endfunction

  way_prio_onehot #(
    .WAY_NUM (WAY_NUM)
  ) u_way_prio (
    .i_vec      (replace_en),
    .o_onehot_c (w_onehot)
  );

  // Accept is qualified by rst_n so nothing leaks out while reset is held
  assign w_accept  = rst_n & (r_state == REFILL_IDLE) & miss_req & (|replace_en);
  assign w_wb      = victim_valid & victim_dirty;
  assign w_last    = (r_cnt == LAST_WORD);
  // LINE_WORDS is a power of two, so the increment wraps to 0 after the last word
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_data_we = (r_state == REFILL_RD) & mem_ack;

  // Refill sequencer: latches the miss on accept, then walks WB -> RD -> COMMIT -> DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= REFILL_IDLE;
      r_cnt      <= '0;
      r_way      <= '0;
      r_index    <= '0;
      r_tag      <= '0;
      r_vtag     <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_tag_we   <= 1'b0;
      r_done     <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      case (r_state)
        REFILL_IDLE: begin
          if (w_accept) begin
            r_way      <= w_onehot;
            r_index    <= miss_index;
            r_tag      <= miss_tag;
            r_vtag     <= victim_tag;
            r_cnt      <= '0;
            r_mem_req  <= 1'b1;
            r_mem_we   <= w_wb;
            r_stall    <= 1'b1;
            r_mem_addr <= beat_addr(w_wb ? victim_tag : miss_tag, miss_index, CW'(0));
            r_state    <= w_wb ? REFILL_WB : REFILL_RD;
          end
        end
        REFILL_WB: begin
          if (mem_ack) begin
            r_cnt <= w_cnt_inc;
            if (w_last) begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= beat_addr(r_tag, r_index, CW'(0));
              r_state    <= REFILL_RD;
            end else begin
              r_mem_addr <= beat_addr(r_vtag, r_index, w_cnt_inc);
            end
          end
        end
        REFILL_RD: begin
          if (mem_ack) begin
            r_cnt <= w_cnt_inc;
            if (w_last) begin
              r_mem_req  <= 1'b0;
              r_mem_addr <= '0;
              r_tag_we   <= 1'b1;
              r_state    <= REFILL_COMMIT;
            end else begin
              r_mem_addr <= beat_addr(r_tag, r_index, w_cnt_inc);
            end
          end
        end
        REFILL_COMMIT: begin
          r_tag_we <= 1'b0;
          r_stall  <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= REFILL_DONE;
        end
        REFILL_DONE: begin
          r_done  <= 1'b0;
          r_state <= REFILL_IDLE;
        end
        default: begin
          r_state <= REFILL_IDLE;
        end
      endcase
    end
  end

  // Output mapping; the same-cycle paths (accept, write data, read fill) are gated by state
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = (r_state == REFILL_WB) ? victim_rdata : '0;
  assign way_sel     = r_way;
  assign arr_index   = r_index;
  assign arr_word    = r_cnt;
  assign data_we     = w_data_we;
  assign data_wdata  = w_data_we ? mem_rdata : '0;
  assign tag_we      = r_tag_we;
  assign tag_wdata   = r_tag;
  assign valid_clr   = w_accept;
  assign stall       = r_stall | w_accept;
  assign refill_done = r_done;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: transaction-script model plus directed pins.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_req;
  logic [20:0] miss_tag;
  logic [6:0]  miss_index;
  logic [3:0]  replace_en;
  logic        victim_valid;
  logic        victim_dirty;
  logic [20:0] victim_tag;
  logic [31:0] victim_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [3:0]  way_sel;
  logic [6:0]  arr_index;
  logic [1:0]  arr_word;
  logic        data_we;
  logic [31:0] data_wdata;
  logic        tag_we;
  logic [20:0] tag_wdata;
  logic        valid_clr;
  logic        stall;
  logic        refill_done;

  logic [31:0] vline [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Victim data array: combinational read of the word the DUT points at
  assign victim_rdata = vline[arr_word];

  cache_refill_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .miss_req     (miss_req),
    .miss_tag     (miss_tag),
    .miss_index   (miss_index),
    .replace_en   (replace_en),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_rdata (victim_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .way_sel      (way_sel),
    .arr_index    (arr_index),
    .arr_word     (arr_word),
    .data_we      (data_we),
    .data_wdata   (data_wdata),
    .tag_we       (tag_we),
    .tag_wdata    (tag_wdata),
    .valid_clr    (valid_clr),
    .stall        (stall),
    .refill_done  (refill_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: per-miss script of expected cycles ----------------
  localparam int K_W = 0;
  localparam int K_R = 1;
  localparam int K_C = 2;
  localparam int K_D = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    int          word;
  } item_t;

  item_t       q[$];
  logic [3:0]  m_way;
  logic [6:0]  m_idx;
  logic [20:0] m_tag;

  function automatic logic [31:0] addr_of(input logic [20:0] t, input logic [6:0] i, input int w);
    return (32'(t) << 11) + (32'(i) << 4) + 32'(w * 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    item_t it;
    bit    found;
    if (!rst_n) begin
      q.delete();
      m_way = '0;
      m_idx = '0;
      m_tag = '0;
    end else if (q.size() == 0) begin
      if (miss_req && replace_en != 4'b0000) begin
        found = 1'b0;
        m_way = '0;
        for (int i = 0; i < 4; i++) begin
          if (!found && replace_en[i]) begin
            m_way[i] = 1'b1;
            found    = 1'b1;
          end
        end
        m_idx = miss_index;
        m_tag = miss_tag;
        if (victim_valid && victim_dirty) begin
          for (int k = 0; k < 4; k++) begin
            it.kind = K_W; it.addr = addr_of(victim_tag, miss_index, k); it.word = k;
            q.push_back(it);
          end
        end
        for (int k = 0; k < 4; k++) begin
          it.kind = K_R; it.addr = addr_of(miss_tag, miss_index, k); it.word = k;
          q.push_back(it);
        end
        it.kind = K_C; it.addr = '0; it.word = 0; q.push_back(it);
        it.kind = K_D; q.push_back(it);
      end
    end else begin
      if (q[0].kind == K_W || q[0].kind == K_R) begin
        if (mem_ack) void'(q.pop_front());
      end else begin
        void'(q.pop_front());
      end
    end
  end

  // Compare process: every out-of-reset cycle, on the falling edge
  always @(negedge clk) begin
    item_t h;
    logic  acc;
    if (rst_n) begin
      if (q.size() == 0) begin
        acc = miss_req && (replace_en != 4'b0000);
        chk("idle_stall", stall, acc);
        chk("idle_valid_clr", valid_clr, acc);
        chk("idle_mem_req", mem_req, 0);
        chk("idle_data_we", data_we, 0);
        chk("idle_tag_we", tag_we, 0);
        chk("idle_refill_done", refill_done, 0);
      end else begin
        h = q[0];
        chk("busy_valid_clr", valid_clr, 0);
        chk("way_sel", way_sel, m_way);
        chk("arr_index", arr_index, m_idx);
        chk("tag_wdata", tag_wdata, m_tag);
        case (h.kind)
          K_W: begin
            chk("wb_mem_req", mem_req, 1);
            chk("wb_mem_we", mem_we, 1);
            chk("wb_mem_addr", mem_addr, h.addr);
            chk("wb_arr_word", arr_word, h.word);
            chk("wb_mem_wdata", mem_wdata, vline[h.word]);
            chk("wb_stall", stall, 1);
            chk("wb_data_we", data_we, 0);
            chk("wb_tag_we", tag_we, 0);
          end
          K_R: begin
            chk("rd_mem_req", mem_req, 1);
            chk("rd_mem_we", mem_we, 0);
            chk("rd_mem_addr", mem_addr, h.addr);
            chk("rd_arr_word", arr_word, h.word);
            chk("rd_stall", stall, 1);
            chk("rd_data_we", data_we, mem_ack);
            if (mem_ack) chk("rd_data_wdata", data_wdata, mem_rdata);
            chk("rd_tag_we", tag_we, 0);
          end
          K_C: begin
            chk("commit_mem_req", mem_req, 0);
            chk("commit_tag_we", tag_we, 1);
            chk("commit_stall", stall, 1);
            chk("commit_data_we", data_we, 0);
            chk("commit_done", refill_done, 0);
          end
          default: begin
            chk("done_refill_done", refill_done, 1);
            chk("done_stall", stall, 0);
            chk("done_mem_req", mem_req, 0);
            chk("done_tag_we", tag_we, 0);
          end
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  // mode: 0 = ack every cycle, 1 = random ack, 2 = three wait cycles before each ack
  task automatic do_miss(
    input  logic [20:0] tag,
    input  logic [6:0]  idx,
    input  logic [3:0]  re,
    input  logic        vv,
    input  logic        vd,
    input  logic [20:0] vtag,
    input  int          mode,
    input  bit          scramble,
    output int          cyc,
    output logic [3:0]  way_seen,
    output logic [31:0] first_addr,
    output bit          saw_vclr
  );
    bit done;
    bit acc;
    bit got_first;
    miss_tag     = tag;
    miss_index   = idx;
    replace_en   = re;
    victim_valid = vv;
    victim_dirty = vd;
    victim_tag   = vtag;
    for (int k = 0; k < 4; k++) vline[k] = $urandom;
    miss_req  = 1'b1;
    mem_ack   = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
    mem_rdata = $urandom;
    cyc = 0; way_seen = '0; first_addr = '0; saw_vclr = 1'b0;
    done = 1'b0; acc = 1'b0; got_first = 1'b0;
    if (re == 4'b0000) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("noway_mem_req", mem_req, 0);
        chk("noway_stall", stall, 0);
        @(posedge clk); #1;
      end
    end else begin
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge clk);
        if (stall || refill_done) cyc++;
        if (valid_clr) saw_vclr = 1'b1;
        if (stall) acc = 1'b1;
        if (mem_req && !got_first) begin
          first_addr = mem_addr;
          way_seen   = way_sel;
          got_first  = 1'b1;
        end
        if (refill_done) begin
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
          case (mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = 1'($urandom_range(0, 1));
            default: mem_ack = (((c + 1) % 4) == 0);
          endcase
          mem_rdata = $urandom;
          if (acc && scramble) begin
            miss_tag     = 21'($urandom);
            miss_index   = 7'($urandom);
            replace_en   = 4'($urandom);
            victim_tag   = 21'($urandom);
            victim_valid = 1'($urandom);
            victim_dirty = 1'($urandom);
          end
        end
      end
      if (!done) chk("refill_timeout", 0, 1);
    end
    @(posedge clk); #1;
    miss_req = 1'b0;
    mem_ack  = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [3:0]  way_seen;
    logic [31:0] first_addr;
    bit          saw_vclr;
    int          nwe;
    logic [13:0] nz;

    rst_n = 1'b0;
    miss_req = 1'b0; miss_tag = '0; miss_index = '0; replace_en = '0;
    victim_valid = 1'b0; victim_dirty = 1'b0; victim_tag = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int k = 0; k < 4; k++) vline[k] = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_stall", stall, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_way_sel", way_sel, 0);
    chk("reset_tag_wdata", tag_wdata, 0);

    // Clean miss, zero-wait memory
    do_miss(21'h1234, 7'h05, 4'b0100, 1'b0, 1'b0, 21'h0AAA, 0, 1'b0, cyc, way_seen, first_addr, saw_vclr);
    chk("clean_cycles", cyc, 7);
    chk("clean_way_sel", way_seen, 4'b0100);
    chk("clean_first_addr", first_addr, 32'h0091_A050);
    chk("clean_valid_clr", saw_vclr, 1);

    // Dirty victim, zero-wait memory
    do_miss(21'h1234, 7'h05, 4'b0001, 1'b1, 1'b1, 21'h0AAA, 0, 1'b0, cyc, way_seen, first_addr, saw_vclr);
    chk("dirty_cycles", cyc, 11);
    chk("dirty_first_addr", first_addr, 32'h0055_5050);

    // Dirty bit without valid is not written back
    do_miss(21'h0042, 7'h7F, 4'b1000, 1'b0, 1'b1, 21'h0AAA, 0, 1'b0, cyc, way_seen, first_addr, saw_vclr);
    chk("invalid_dirty_cycles", cyc, 7);

    // Three wait states per beat
    do_miss(21'h0101, 7'h33, 4'b0010, 1'b0, 1'b0, 21'h0000, 2, 1'b0, cyc, way_seen, first_addr, saw_vclr);
    chk("wait_clean_cycles", cyc, 19);
    do_miss(21'h0202, 7'h44, 4'b0010, 1'b1, 1'b1, 21'h1F0F0, 2, 1'b1, cyc, way_seen, first_addr, saw_vclr);
    chk("wait_dirty_cycles", cyc, 35);

    // Multi-hot victim vector picks the lowest way
    do_miss(21'h0333, 7'h01, 4'b0110, 1'b0, 1'b0, 21'h0, 0, 1'b0, cyc, way_seen, first_addr, saw_vclr);
    chk("multihot_way_sel", way_seen, 4'b0010);

    // No victim way: request ignored
    do_miss(21'h0444, 7'h02, 4'b0000, 1'b1, 1'b1, 21'h0, 0, 1'b0, cyc, way_seen, first_addr, saw_vclr);

    // Reset in the middle of RD after two words
    miss_tag = 21'h0777; miss_index = 7'h12; replace_en = 4'b0001;
    victim_valid = 1'b0; victim_dirty = 1'b0; victim_tag = '0;
    miss_req = 1'b1; mem_ack = 1'b1; mem_rdata = $urandom;
    nwe = 0; saw_vclr = 1'b0;
    for (int c = 0; c < 50 && nwe < 2; c++) begin
      @(negedge clk);
      if (valid_clr) saw_vclr = 1'b1;
      if (data_we) nwe++;
      if (nwe < 2) begin
        @(posedge clk); #1;
        mem_rdata = $urandom;
      end
    end
    chk("pre_reset_words", nwe, 2);
    chk("pre_reset_valid_clr", saw_vclr, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    nz = {mem_req, mem_we, |mem_addr, |mem_wdata, |way_sel, |arr_index, |arr_word,
          data_we, |data_wdata, tag_we, |tag_wdata, valid_clr, stall, refill_done};
    chk("midrd_reset_outputs", nz, 14'h0);
    @(negedge clk);
    miss_req = 1'b0; mem_ack = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_miss(21'h0777, 7'h12, 4'b0001, 1'b0, 1'b0, 21'h0, 0, 1'b0, cyc, way_seen, first_addr, saw_vclr);
    chk("after_reset_first_addr", first_addr, 32'h003B_B920);
    chk("after_reset_cycles", cyc, 7);

    // Randomized misses checked by the model
    for (int t = 0; t < 40; t++) begin
      do_miss(21'($urandom), 7'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              21'($urandom), int'($urandom_range(0, 2)), 1'b1, cyc, way_seen, first_addr, saw_vclr);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
